sfq_edge_deserializer: RTL and testbench
========================================

Name: sfq_edge_deserializer

Overview:
- Downstream consumer of the RSFQ DFF behavioural stage. It converts the cell's edge-coded pulse outputs into synchronous parallel words for the conventional-logic test harness.
- Edge coding: every transition on an input, rising or falling, is one SFQ pulse.
- The block samples the SFQ clock stream and the DFF q stream on a fast synchronous clock. It forms one bit per SFQ clock period and packs the bits into WIDTH-bit words with a valid/ready output.
- Window errors and overflow are reported on sticky flags.

Parameters:
- WIDTH, 8, bits per output word (2..32).
- SYNC_STAGES, 2, synchronizer flops per edge-coded input (2..4).
- MSB_FIRST, 1, 1 = first captured bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].

Ports:
- clk  input  1  sampling clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sfq_clk_in  input  1  edge-coded SFQ clock stream; the same stream that drives the DFF clk.
- sfq_q_in  input  1  edge-coded DFF q output.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- err_double  output  1  sticky: two or more q pulses arrived in one window.
- err_overflow  output  1  sticky: a word completed while the output holding register was occupied.

Behaviour:
- Interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then one history flop.
  - A pulse is detected when the synchronized value XOR the history value equals 1.
  - Detection latency is SYNC_STAGES+1 clk cycles, identical for both inputs, so relative alignment is preserved.
  - Input pulses closer together than 2 clk cycles are out of spec.
- Window definition:
  - A detected sfq_clk pulse closes the current window and opens the next.
  - The bit for a closed window is 1 if at least one q pulse was detected inside it, otherwise 0.
  - A q pulse detected in the same cycle as an sfq_clk pulse counts toward the closing window, because DFF output follows its clock.
- State machine, two states:
  - WAIT_FIRST (reset state): the first sfq_clk pulse opens window 0, emits no bit, and moves to RUN. q pulses seen in WAIT_FIRST are ignored.
  - RUN: each sfq_clk pulse emits one bit into the shift register and increments the bit counter, 0..WIDTH-1.
- Packing:
  - When the counter wraps from WIDTH-1 to 0, the assembled word (including the bit emitted that cycle) is transferred to the output register and out_valid is set on the next edge.
  - Bit order follows MSB_FIRST.
- Handshake:
  - out_data is stable while out_valid=1.
  - out_valid clears on the edge where out_valid && out_ready.
  - If a word completes in the same cycle as an accept, the new word loads and out_valid stays 1; this is not an overflow.
  - If a word completes while out_valid=1 && !out_ready, the new word is dropped, the output is unchanged, and err_overflow is set.
- Error flags:
  - err_double is set when a second q pulse is detected within an open window. The bit for that window is still 1.
  - Both error flags clear only on rst.
- Reset values: out_data=0, out_valid=0, err_double=0, err_overflow=0, state=WAIT_FIRST, counter=0, shift register=0, synchronizer and history flops = current raw input value loaded directly. This avoids a spurious pulse after reset.
- Reset mid-word: the partial word is discarded and the block returns to WAIT_FIRST. Reset has priority over all other events in the same cycle.

Optional Feature:
- Macro: SFQ_DESER_ERRCNT_EN.
- Defined: adds output err_count[15:0], reset to 0. It increments by 1 per err_double event plus 1 per err_overflow event. If both occur in the same cycle it increments by 2. It saturates at 16'hFFFF.
- Undefined: the port and counter are absent; the sticky flags are unchanged.

Test Plan:
- WIDTH=8, MSB_FIRST=1: 9 sfq_clk pulses, q pulse in windows for bits 1,0,1,1,0,0,1,0, out_ready=1 -> one word 8'hB2, out_valid high 1 cycle, no error flags.
- MSB_FIRST=0, same stimulus -> out_data=8'h4D.
- q pulse in the same cycle as the closing sfq_clk pulse, all 8 windows -> word 8'hFF. q pulses before the first sfq_clk are ignored.
- Two q pulses in window 3 of an otherwise empty word -> 8'h10 (MSB_FIRST=1), err_double=1, and it stays 1 across further words until rst. With SFQ_DESER_ERRCNT_EN defined, err_count=1.
- out_ready=0, 16 bit-windows (two words) -> first word held, second dropped, err_overflow=1. Then out_ready=1 -> first word accepted, out_valid=0.
- rst asserted after 5 bits of a word -> outputs zero. Next 9 sfq_clk pulses produce a full word from fresh bits only; no spurious pulse is detected on the first cycle after reset.

Source files
------------

// File: rtl/sfq_edge_deserializer.sv
// sfq_edge_deserializer
//   Turns the edge-coded pulse streams of the RSFQ DFF stage into parallel
//   WIDTH-bit words for the conventional-logic harness. Every transition on
//   an input is one SFQ pulse. Each sfq_clk pulse closes a bit window: the
//   bit is 1 when at least one q pulse arrived in that window.
//
// Ports
//   clk           sampling clock, rising edge
//   rst           synchronous, active-high reset
//   sfq_clk_in    edge-coded SFQ clock stream (also clocks the DFF)
//   sfq_q_in      edge-coded DFF q stream
//   out_data      completed word, stable while out_valid
//   out_valid     out_data holds an unconsumed word
//   out_ready     consumer accepts on out_valid && out_ready
//   err_double    sticky: two or more q pulses in one window
//   err_overflow  sticky: a word completed while the holding register was full
//   err_count     only with SFQ_DESER_ERRCNT_EN defined: saturating count of
//                 err_double and err_overflow events
//
// Optional feature macro: SFQ_DESER_ERRCNT_EN
module sfq_edge_deserializer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_clk_in,
  input  logic             sfq_q_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_double,
  output logic             err_overflow
`ifdef SFQ_DESER_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {WAIT_FIRST, RUN} state_t;

  // Input conditioning: synchronizer chain plus one history flop per input.
  // Both inputs see identical latency, so a q pulse keeps its position
  // relative to the sfq_clk pulse that follows it.
  logic [SYNC_STAGES-1:0] ck_sync, q_sync;
  logic                   ck_hist, q_hist;
  logic                   ck_pulse, q_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Load the live input level so a non-zero line does not look like
      // a transition on the first cycle after reset.
      ck_sync <= {SYNC_STAGES{sfq_clk_in}};
      q_sync  <= {SYNC_STAGES{sfq_q_in}};
      ck_hist <= sfq_clk_in;
      q_hist  <= sfq_q_in;
    end else begin
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], sfq_clk_in};
      q_sync  <= {q_sync[SYNC_STAGES-2:0], sfq_q_in};
      ck_hist <= ck_sync[SYNC_STAGES-1];
      q_hist  <= q_sync[SYNC_STAGES-1];
    end
  end

  assign ck_pulse = ck_sync[SYNC_STAGES-1] ^ ck_hist;
  assign q_pulse  = q_sync[SYNC_STAGES-1] ^ q_hist;

  // Window state machine
  state_t state, state_nx;
  logic   emit;   // an sfq_clk pulse closes a window and produces a bit
  logic   q_acc;  // q pulse that belongs to an open window

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_FIRST;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    q_acc    = 1'b0;
    case (state)
      WAIT_FIRST: begin
        // First clock pulse only opens window 0; q activity is ignored.
        if (ck_pulse) state_nx = RUN;
      end
      RUN: begin
        emit  = ck_pulse;
        q_acc = q_pulse;
      end
      default: state_nx = WAIT_FIRST;
    endcase
  end

  // Bit assembly
  logic             q_seen;
  logic [WIDTH-1:0] shreg, shifted;
  logic [CW-1:0]    bit_cnt;
  logic             bit_val, word_done, dbl_evt, ovf_evt;

  always_comb begin
    // A q pulse coincident with the closing clock pulse still counts for
    // the closing window: the DFF output follows its own clock.
    bit_val   = q_seen | q_acc;
    dbl_evt   = q_acc & q_seen;
    word_done = emit && (bit_cnt == LAST);
    ovf_evt   = word_done && out_valid && !out_ready;
    if (MSB_FIRST) shifted = {shreg[WIDTH-2:0], bit_val};
    else           shifted = {bit_val, shreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_seen       <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      err_double   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (emit)       q_seen <= 1'b0;
      else if (q_acc) q_seen <= 1'b1;

      if (emit) begin
        shreg   <= word_done ? '0 : shifted;
        bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      end

      // A completing word may replace one being accepted this very cycle;
      // otherwise a full holding register drops the new word.
      if (word_done && (!out_valid || out_ready)) begin
        out_data  <= shifted;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (dbl_evt) err_double   <= 1'b1;
      if (ovf_evt) err_overflow <= 1'b1;
    end
  end

`ifdef SFQ_DESER_ERRCNT_EN
  logic [1:0]  cnt_inc;
  logic [16:0] cnt_sum;

  always_comb begin
    cnt_inc = {1'b0, dbl_evt} + {1'b0, ovf_evt};
    cnt_sum = {1'b0, err_count} + {15'd0, cnt_inc};
  end

  always_ff @(posedge clk) begin
    if (rst)             err_count <= '0;
    else if (cnt_sum[16]) err_count <= 16'hFFFF;
    else                 err_count <= cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_sfq_edge_deserializer.sv
module tb_sfq_edge_deserializer;
  localparam int W = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic sfq_clk_in = 1'b0, sfq_q_in = 1'b0, out_ready = 1'b1;
  logic [W-1:0] m_data, l_data;
  logic m_valid, l_valid, m_dbl, l_dbl, m_ovf, l_ovf;
`ifdef SFQ_DESER_ERRCNT_EN
  logic [15:0] m_cnt, l_cnt;
`endif

  always #5 clk = ~clk;

  sfq_edge_deserializer #(.WIDTH(W), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .sfq_clk_in(sfq_clk_in), .sfq_q_in(sfq_q_in),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .err_double(m_dbl), .err_overflow(m_ovf)
`ifdef SFQ_DESER_ERRCNT_EN
    , .err_count(m_cnt)
`endif
  );

  sfq_edge_deserializer #(.WIDTH(W), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .sfq_clk_in(sfq_clk_in), .sfq_q_in(sfq_q_in),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .err_double(l_dbl), .err_overflow(l_ovf)
`ifdef SFQ_DESER_ERRCNT_EN
    , .err_count(l_cnt)
`endif
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: event level, one bit per clock window.
  bit           started;
  int           qcnt;
  bit           bits[$];
  logic [W-1:0] exp_m[$], exp_l[$];
  bit           exp_dbl;
  int           exp_cnt;

  task automatic model_reset();
    started = 0; qcnt = 0; bits.delete();
    exp_m.delete(); exp_l.delete(); exp_dbl = 0; exp_cnt = 0;
  endtask

  task automatic model_event(input bit c, input bit q);
    logic [W-1:0] wm, wl;
    if (!started) begin
      if (c) begin started = 1; qcnt = 0; end
    end else begin
      if (q) begin
        if (qcnt > 0) begin exp_dbl = 1; exp_cnt++; end
        qcnt++;
      end
      if (c) begin
        bits.push_back(qcnt > 0);
        qcnt = 0;
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits[i];
            wl[i]     = bits[i];
          end
          exp_m.push_back(wm); exp_l.push_back(wl);
          bits.delete();
        end
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic [W-1:0] got_m[$], got_l[$];
  int vcyc;
  always @(negedge clk) begin
    if (m_valid) vcyc++;
    if (m_valid && out_ready) got_m.push_back(m_data);
    if (l_valid && out_ready) got_l.push_back(l_data);
  end

  task automatic pulse(input bit c, input bit q, input int gap);
    @(posedge clk); #1;
    if (c) sfq_clk_in = ~sfq_clk_in;
    if (q) sfq_q_in   = ~sfq_q_in;
    model_event(c, q);
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_word(input logic [7:0] pat, input bit same);
    for (int i = 0; i < W; i++) begin
      if (pat[7-i] && !same) pulse(1'b0, 1'b1, 3);
      pulse(1'b1, pat[7-i] && same, 3);
    end
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    got_m.delete(); got_l.delete();
  endtask

  task automatic pop_chk(input string name, input logic [7:0] em, input logic [7:0] el);
    chk({name, "_cnt"}, got_m.size(), 1);
    if (got_m.size() > 0) chk({name, "_msb"}, got_m.pop_front(), em);
    chk({name, "_lcnt"}, got_l.size(), 1);
    if (got_l.size() > 0) chk({name, "_lsb"}, got_l.pop_front(), el);
  endtask

  typedef struct {
    logic [7:0] pat;
    bit         same;
    logic [7:0] m;
    logic [7:0] l;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'hB2, 1'b0, 8'hB2, 8'h4D};
    tbl[1] = '{8'hFF, 1'b1, 8'hFF, 8'hFF};
    tbl[2] = '{8'h00, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{8'h81, 1'b0, 8'h81, 8'h81};
    tbl[4] = '{8'hF0, 1'b1, 8'hF0, 8'h0F};
    tbl[5] = '{8'h1A, 1'b0, 8'h1A, 8'h58};
    model_reset();
    vcyc = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_dbl", m_dbl, 0);
    chk("rst_ovf", m_ovf, 0);

    // q activity before the first sfq_clk pulse is ignored
    pulse(0, 1, 3); pulse(0, 1, 3); pulse(0, 1, 3);
    pulse(1, 0, 3);
    for (int v = 0; v < 6; v++) begin
      vcyc = 0;
      send_word(tbl[v].pat, tbl[v].same);
      drain();
      pop_chk($sformatf("vec%0d", v), tbl[v].m, tbl[v].l);
      chk($sformatf("vec%0d_vcyc", v), vcyc, 1);
      chk($sformatf("vec%0d_dbl", v), m_dbl, 0);
      chk($sformatf("vec%0d_ovf", v), m_ovf, 0);
    end

    // Two q pulses in window 3
    do_reset();
    pulse(1, 0, 3);
    repeat (3) pulse(1, 0, 3);
    pulse(0, 1, 3); pulse(0, 1, 3); pulse(1, 0, 3);
    repeat (4) pulse(1, 0, 3);
    drain();
    pop_chk("dbl", 8'h10, 8'h08);
    chk("dbl_flag", m_dbl, 1);
    chk("dbl_flag_l", l_dbl, 1);
`ifdef SFQ_DESER_ERRCNT_EN
    chk("dbl_errcnt", m_cnt, 1);
`endif
    send_word(8'h00, 0);
    drain();
    pop_chk("dbl_next", 8'h00, 8'h00);
    chk("dbl_sticky", m_dbl, 1);
    do_reset();
    @(negedge clk);
    chk("dbl_cleared", m_dbl, 0);

    // Overflow: second word dropped while the first is held
    out_ready = 1'b0;
    pulse(1, 0, 3);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    drain();
    chk("ovf_valid", m_valid, 1);
    chk("ovf_data", m_data, 8'hA5);
    chk("ovf_flag", m_ovf, 1);
    chk("ovf_dbl", m_dbl, 0);
`ifdef SFQ_DESER_ERRCNT_EN
    chk("ovf_errcnt", m_cnt, 1);
`endif
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovf_accept_valid", m_valid, 0);
    chk("ovf_accept_cnt", got_m.size(), 1);
    if (got_m.size() > 0) chk("ovf_accept_data", got_m.pop_front(), 8'hA5);

    // Reset mid-word with both raw lines left high
    do_reset();
    pulse(1, 0, 3);
    pulse(0, 1, 3); pulse(1, 0, 3);
    pulse(1, 0, 3);
    pulse(0, 1, 3); pulse(1, 0, 3);
    pulse(0, 1, 3); pulse(1, 0, 3);
    pulse(1, 0, 3);
    @(posedge clk); #1;
    if (sfq_clk_in == 1'b0) sfq_clk_in = 1'b1;
    if (sfq_q_in == 1'b0) sfq_q_in = 1'b1;
    repeat (8) @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("mid_valid", m_valid, 0);
    chk("mid_data", m_data, 0);
    chk("mid_ovf", m_ovf, 0);
    repeat (4) @(negedge clk);
    chk("mid_nopartial", got_m.size(), 0);
    pulse(1, 0, 3);
    send_word(8'hC6, 0);
    drain();
    pop_chk("mid_word", 8'hC6, 8'h63);

    // Randomized windows against the model
    do_reset();
    pulse(1, 0, 2);
    for (int w = 0; w < 40; w++) begin
      int n, nq;
      bit same;
      n    = $urandom_range(0, 9);
      nq   = (n < 4) ? 0 : ((n < 8) ? 1 : 2);
      same = (nq > 0) && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < nq - int'(same); k++) pulse(0, 1, 2 + $urandom_range(0, 2));
      pulse(1, same, 2 + $urandom_range(0, 2));
    end
    drain();
    chk("rnd_cnt", got_m.size(), exp_m.size());
    chk("rnd_lcnt", got_l.size(), exp_l.size());
    while (got_m.size() > 0 && exp_m.size() > 0)
      chk("rnd_msb", got_m.pop_front(), exp_m.pop_front());
    while (got_l.size() > 0 && exp_l.size() > 0)
      chk("rnd_lsb", got_l.pop_front(), exp_l.pop_front());
    chk("rnd_dbl", m_dbl, exp_dbl);
    chk("rnd_ovf", m_ovf, 0);
`ifdef SFQ_DESER_ERRCNT_EN
    chk("rnd_errcnt", m_cnt, exp_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
